// File: rtl/timer.sv
// timer: down-counting interval timer on a wishbone-style slave port, with pending flag and level irq.
// Define TIMER_PRESCALER_EN to build the 8-bit prescaler and CTRL[15:8]; without it every enabled cycle ticks.
module timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_i,
    input  logic [3:0]  adr_i,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel_i,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic [31:0] dat_o,
    output logic        irq_o
);
    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_COUNT  = 2'd1;
    localparam logic [1:0] REG_RELOAD = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v, input logic [31:0] new_v,
                                                input logic [3:0] sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [31:0] lane_mask(input logic [31:0] data, input logic [3:0] sel);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = sel[i] ? data[8*i +: 8] : 8'h00;
        end
        return res;
    endfunction

    logic                 en_r, periodic_r, irq_en_r, pending_r;
    logic [CNT_WIDTH-1:0] count_r, reload_r;
    logic                 en_n_s, periodic_n_s, irq_en_n_s, pending_n_s;
    logic [CNT_WIDTH-1:0] count_n_s, reload_n_s;
`ifdef TIMER_PRESCALER_EN
    logic [7:0]           prescale_r, pc_r, prescale_n_s, pc_n_s;
`endif

    logic        acc_s, wr_s, rd_s;
    logic [1:0]  reg_s;
    logic        wr_ctrl_s, wr_count_s, wr_reload_s, wr_status_s;
    logic [31:0] ctrl_rd_s, count_rd_s, reload_rd_s, status_rd_s, rd_data_s;
    logic [31:0] ctrl_wr_s, count_wr_s, reload_wr_s;
    logic        tick_s, tick_eff_s, expire_s, clr_pend_s;
    logic        unused_s;

    assign unused_s = ^{adr_i[1:0], ctrl_wr_s, count_wr_s, reload_wr_s};

    // Bus access decode: a new access starts whenever stb is seen outside an ack cycle.
    always_comb begin
        acc_s       = stb_i & ~ack_o;
        wr_s        = acc_s & we_i;
        rd_s        = acc_s & ~we_i;
        reg_s       = adr_i[3:2];
        wr_ctrl_s   = wr_s & (reg_s == REG_CTRL);
        wr_count_s  = wr_s & (reg_s == REG_COUNT);
        wr_reload_s = wr_s & (reg_s == REG_RELOAD);
        wr_status_s = wr_s & (reg_s == REG_STATUS);
    end

    // Register read images, lane-masked read mux and byte-merged write values.
    always_comb begin
        ctrl_rd_s      = 32'h0000_0000;
        ctrl_rd_s[2:0] = {irq_en_r, periodic_r, en_r};
`ifdef TIMER_PRESCALER_EN
        ctrl_rd_s[15:8] = prescale_r;
`endif
        count_rd_s                  = 32'h0000_0000;
        count_rd_s[CNT_WIDTH-1:0]   = count_r;
        reload_rd_s                 = 32'h0000_0000;
        reload_rd_s[CNT_WIDTH-1:0]  = reload_r;
        status_rd_s                 = {31'h0000_0000, pending_r};
        case (reg_s)
            REG_CTRL:   rd_data_s = lane_mask(ctrl_rd_s, sel_i);
            REG_COUNT:  rd_data_s = lane_mask(count_rd_s, sel_i);
            REG_RELOAD: rd_data_s = lane_mask(reload_rd_s, sel_i);
            REG_STATUS: rd_data_s = lane_mask(status_rd_s, sel_i);
            default:    rd_data_s = 32'h0000_0000;
        endcase
        ctrl_wr_s   = merge_bytes(ctrl_rd_s, dat_i, sel_i);
        count_wr_s  = merge_bytes(count_rd_s, dat_i, sel_i);
        reload_wr_s = merge_bytes(reload_rd_s, dat_i, sel_i);
    end

    // Tick generation; a COUNT write in the same cycle discards the tick entirely.
    always_comb begin
`ifdef TIMER_PRESCALER_EN
        tick_s = en_r & (pc_r == prescale_r);
`else
        tick_s = en_r;
`endif
        tick_eff_s = tick_s & ~wr_count_s;
        expire_s   = tick_eff_s & (count_r == CNT_ZERO);
        clr_pend_s = wr_status_s & sel_i[0] & dat_i[0];
    end

    // Next-state: tick effects first, bus writes afterwards so the written value wins.
    always_comb begin
        en_n_s       = en_r;
        periodic_n_s = periodic_r;
        irq_en_n_s   = irq_en_r;
        count_n_s    = count_r;
        reload_n_s   = reload_r;
        if (tick_eff_s) begin
            if (count_r != CNT_ZERO) begin
                count_n_s = count_r - CNT_ONE;
            end else if (periodic_r) begin
                count_n_s = reload_r;
            end else begin
                en_n_s = 1'b0;
            end
        end else begin
            count_n_s = count_r;
        end
        // Expiry beats a simultaneous W1C.
        if (expire_s) begin
            pending_n_s = 1'b1;
        end else if (clr_pend_s) begin
            pending_n_s = 1'b0;
        end else begin
            pending_n_s = pending_r;
        end
        if (wr_count_s) begin
            count_n_s = count_wr_s[CNT_WIDTH-1:0];
        end else begin
            count_n_s = count_n_s;
        end
        if (wr_reload_s) begin
            reload_n_s = reload_wr_s[CNT_WIDTH-1:0];
        end else begin
            reload_n_s = reload_r;
        end
`ifdef TIMER_PRESCALER_EN
        prescale_n_s = prescale_r;
        if (wr_ctrl_s | ~en_r | tick_s) begin
            pc_n_s = 8'h00;
        end else begin
            pc_n_s = pc_r + 8'h01;
        end
`endif
        if (wr_ctrl_s) begin
            en_n_s       = ctrl_wr_s[0];
            periodic_n_s = ctrl_wr_s[1];
            irq_en_n_s   = ctrl_wr_s[2];
`ifdef TIMER_PRESCALER_EN
            prescale_n_s = ctrl_wr_s[15:8];
`endif
        end else begin
            periodic_n_s = periodic_r;
        end
    end

    // State and bus output registers with synchronous reset overriding every event.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            en_r       <= 1'b0;
            periodic_r <= 1'b0;
            irq_en_r   <= 1'b0;
            pending_r  <= 1'b0;
            count_r    <= CNT_ZERO;
            reload_r   <= CNT_ZERO;
            ack_o      <= 1'b0;
            dat_o      <= 32'h0000_0000;
`ifdef TIMER_PRESCALER_EN
            prescale_r <= 8'h00;
            pc_r       <= 8'h00;
`endif
        end else begin
            en_r       <= en_n_s;
            periodic_r <= periodic_n_s;
            irq_en_r   <= irq_en_n_s;
            pending_r  <= pending_n_s;
            count_r    <= count_n_s;
            reload_r   <= reload_n_s;
            ack_o      <= acc_s;
            if (rd_s) begin
                dat_o <= rd_data_s;
            end else begin
                dat_o <= dat_o;
            end
`ifdef TIMER_PRESCALER_EN
            prescale_r <= prescale_n_s;
            pc_r       <= pc_n_s;
`endif
        end
    end

    assign irq_o = pending_r & irq_en_r;

endmodule
